// File: rtl/fc_requant_pipe.sv
// fc_requant_pipe: 4-stage requantizer (bias, ReLU, multiply, rounding shift, zero point, narrow).
// Build option FC_REQUANT_SAT_EN: clamp to the output range and expose the sticky o_sat_flag.
module fc_requant_pipe #(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned MULT_W = 32,
  localparam int unsigned CFG8_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_wr,
  input  logic [MULT_W-1:0] i_cfg_mult,
  input  logic [CFG8_W-1:0] i_cfg_shift,
  input  logic [CFG8_W-1:0] i_cfg_zp,
  input  logic              i_cfg_relu,
  output logic              o_cfg_err,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [ACC_W-1:0]  i_bias,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_act,
  output logic              o_last,
  output logic [CNT_W-1:0]  o_count,
`ifdef FC_REQUANT_SAT_EN
  output logic              o_sat_flag,
`endif
  output logic              o_busy
);

  localparam int unsigned PROD_W = ACC_W + MULT_W;
  localparam int unsigned Y_W    = 16;
  localparam int unsigned TS_W   = 6;
  localparam int unsigned TSR_W  = 10;
  localparam logic signed [Y_W-1:0] ACT_MAX = Y_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [Y_W-1:0] ACT_MIN = ~ACT_MAX;

  logic signed [MULT_W-1:0] cfg_mult_q, cfg_mult_d;
  logic signed [CFG8_W-1:0] cfg_shift_q, cfg_shift_d;
  logic signed [CFG8_W-1:0] cfg_zp_q, cfg_zp_d;
  logic                     cfg_relu_q, cfg_relu_d;
  logic                     cfg_err_q, cfg_err_d;

  logic v1_q, v2_q, v3_q, v4_q, v1_d, v2_d, v3_d, v4_d;
  logic l1_q, l2_q, l3_q, l4_q, l1_d, l2_d, l3_d, l4_d;
  logic signed [ACC_W-1:0]  r_q, r_d;
  logic signed [PROD_W-1:0] p_q, p_d;
  logic signed [Y_W-1:0]    q_q, q_d;
  logic [OUT_W-1:0]         act_q, act_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     sat_q, sat_d;

  logic                     en_c, cfg_acc_c, sat_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [TSR_W-1:0]  ts_raw_c;
  logic [TS_W-1:0]          ts_c;
  logic signed [PROD_W-1:0] rnd_c;
  logic signed [Y_W-1:0]    y_c, yc_c;

  assign en_c      = !v4_q || i_ready;
  assign o_ready   = en_c;
  assign o_valid   = v4_q;
  assign o_act     = act_q;
  assign o_last    = l4_q;
  assign o_count   = cnt_q;
  assign o_busy    = busy_q;
  assign o_cfg_err = cfg_err_q;
`ifdef FC_REQUANT_SAT_EN
  assign o_sat_flag = sat_q;
`endif

  // Datapath arithmetic for each stage plus config/counter next-state.
  always_comb begin
    sum_c    = $signed(i_acc) + $signed(i_bias);
    ts_raw_c = 10'sd31 - TSR_W'(cfg_shift_q);
    if (ts_raw_c < 10'sd1)       ts_c = TS_W'(1);
    else if (ts_raw_c > 10'sd62) ts_c = TS_W'(62);
    else                         ts_c = ts_raw_c[TS_W-1:0];
    rnd_c = PROD_W'(1) << (ts_c - TS_W'(1));
    y_c   = q_q + Y_W'(cfg_zp_q);
    yc_c  = y_c;
    sat_c = 1'b0;
`ifdef FC_REQUANT_SAT_EN
    if (y_c > ACT_MAX) begin
      yc_c  = ACT_MAX;
      sat_c = 1'b1;
    end else if (y_c < ACT_MIN) begin
      yc_c  = ACT_MIN;
      sat_c = 1'b1;
    end
`endif

    v1_d = v1_q; v2_d = v2_q; v3_d = v3_q; v4_d = v4_q;
    l1_d = l1_q; l2_d = l2_q; l3_d = l3_q; l4_d = l4_q;
    r_d = r_q; p_d = p_q; q_d = q_q; act_d = act_q;
    if (en_c) begin
      v1_d  = i_valid;
      l1_d  = i_last;
      r_d   = (cfg_relu_q && sum_c < 0) ? '0 : sum_c;
      v2_d  = v1_q;
      l2_d  = l1_q;
      p_d   = PROD_W'(r_q) * PROD_W'(cfg_mult_q);
      v3_d  = v2_q;
      l3_d  = l2_q;
      q_d   = Y_W'((p_q + rnd_c) >>> ts_c);
      v4_d  = v3_q;
      l4_d  = l3_q;
      act_d = OUT_W'(yc_c);
    end
    busy_d = v1_d || v2_d || v3_d || v4_d;

    // Config only changes with an empty pipeline, so stages read it directly.
    cfg_acc_c   = i_cfg_wr && !busy_q && !i_valid;
    cfg_err_d   = i_cfg_wr && !cfg_acc_c;
    cfg_mult_d  = cfg_mult_q;
    cfg_shift_d = cfg_shift_q;
    cfg_zp_d    = cfg_zp_q;
    cfg_relu_d  = cfg_relu_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    if (cfg_acc_c) begin
      cfg_mult_d  = $signed(i_cfg_mult);
      cfg_shift_d = $signed(i_cfg_shift);
      cfg_zp_d    = $signed(i_cfg_zp);
      cfg_relu_d  = i_cfg_relu;
      cnt_d       = '0;
      sat_d       = 1'b0;
    end else begin
      if (v4_q && i_ready && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (en_c && v3_q && sat_c)          sat_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_mult_q  <= '0;
      cfg_shift_q <= '0;
      cfg_zp_q    <= '0;
      cfg_relu_q  <= 1'b1;
      cfg_err_q   <= 1'b0;
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; v4_q <= 1'b0;
      l1_q <= 1'b0; l2_q <= 1'b0; l3_q <= 1'b0; l4_q <= 1'b0;
      r_q    <= '0;
      p_q    <= '0;
      q_q    <= '0;
      act_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cfg_mult_q  <= cfg_mult_d;
      cfg_shift_q <= cfg_shift_d;
      cfg_zp_q    <= cfg_zp_d;
      cfg_relu_q  <= cfg_relu_d;
      cfg_err_q   <= cfg_err_d;
      v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d; v4_q <= v4_d;
      l1_q <= l1_d; l2_q <= l2_d; l3_q <= l3_d; l4_q <= l4_d;
      r_q    <= r_d;
      p_q    <= p_d;
      q_q    <= q_d;
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      sat_q  <= sat_d;
    end
  end

endmodule

// File: tb/tb_fc_requant_pipe.sv
// Directed self-checking bench for fc_requant_pipe (default wrap build or FC_REQUANT_SAT_EN).
module tb_fc_requant_pipe;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam logic [31:0] M_HALF = 32'h4000_0000;
  localparam logic [31:0] M_QTR  = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  logic cfg_wr;
  logic [31:0] cfg_mult;
  logic [7:0] cfg_shift, cfg_zp;
  logic cfg_relu, cfg_err;
  logic in_valid, out_ready, in_last;
  logic [ACC_W-1:0] acc, bias;
  logic out_valid, ds_ready, out_last, busy;
  logic [OUT_W-1:0] act;
  logic [CNT_W-1:0] count;
`ifdef FC_REQUANT_SAT_EN
  logic sat_flag;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fc_requant_pipe #(.ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_wr(cfg_wr), .i_cfg_mult(cfg_mult), .i_cfg_shift(cfg_shift),
    .i_cfg_zp(cfg_zp), .i_cfg_relu(cfg_relu), .o_cfg_err(cfg_err),
    .i_valid(in_valid), .o_ready(out_ready), .i_acc(acc), .i_bias(bias),
    .i_last(in_last), .o_valid(out_valid), .i_ready(ds_ready),
    .o_act(act), .o_last(out_last), .o_count(count),
`ifdef FC_REQUANT_SAT_EN
    .o_sat_flag(sat_flag),
`endif
    .o_busy(busy)
  );

  // Drive helpers (called at a falling edge, return at a falling edge).
  task automatic do_cfg(input logic [31:0] m, input logic [7:0] s, input logic [7:0] z,
                        input logic r);
    cfg_mult = m; cfg_shift = s; cfg_zp = z; cfg_relu = r; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b, input logic l);
    in_valid = 1'b1; acc = a; bias = b; in_last = l;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Edges since the transfer edge until o_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (act !== 8'h00) begin errors++; $display("FAIL reset_act got=%h exp=00", act); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got=%0b exp=0", out_last); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got=%0b exp=0", cfg_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", out_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rounding;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [7:0]  ev [3];
    int lat;
    av[0] = 32'd1;    bv[0] = 32'd0;  ev[0] = 8'h01;
    av[1] = 32'd3;    bv[1] = 32'd0;  ev[1] = 8'h02;
    av[2] = 32'd1000; bv[2] = 32'd24;
`ifdef FC_REQUANT_SAT_EN
    ev[2] = 8'h7F;
`else
    ev[2] = 8'h00;
`endif
    do_cfg(M_HALF, 8'd0, 8'd0, 1'b1);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL round_cfg_err got=%0b exp=0", cfg_err); end
    for (int i = 0; i < 3; i++) begin
      drive_beat(av[i], bv[i], 1'b0);
      wait_out(lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL round_latency[%0d] got=%0d exp=4", i, lat); end
      checks++; if (act !== ev[i]) begin errors++; $display("FAIL round_act[%0d] got=%h exp=%h", i, act, ev[i]); end
    end
`ifdef FC_REQUANT_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL round_sat_flag got=%0b exp=1", sat_flag); end
`endif
    @(negedge clk);
  endtask

  task automatic test_relu;
    int lat;
    logic [7:0] exp_bypass;
`ifdef FC_REQUANT_SAT_EN
    exp_bypass = 8'h80;
`else
    exp_bypass = 8'h0B;
`endif
    do_cfg(M_HALF, 8'd0, 8'd5, 1'b1);
    drive_beat(-32'sd500, 32'd0, 1'b0);
    wait_out(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL relu_on_latency got=%0d exp=4", lat); end
    checks++; if (act !== 8'h05) begin errors++; $display("FAIL relu_on_act got=%h exp=05", act); end
    @(negedge clk);
    do_cfg(M_HALF, 8'd0, 8'd5, 1'b0);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL relu_cfg_err got=%0b exp=0", cfg_err); end
    drive_beat(-32'sd500, 32'd0, 1'b0);
    wait_out(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL relu_off_latency got=%0d exp=4", lat); end
    checks++; if (act !== exp_bypass) begin errors++; $display("FAIL relu_off_act got=%h exp=%h", act, exp_bypass); end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    int lat;
    logic [7:0] exp_act;
`ifdef FC_REQUANT_SAT_EN
    exp_act = 8'h7F;
`else
    exp_act = 8'h80;
`endif
    do_cfg(M_HALF, 8'd0, 8'h80, 1'b1);
`ifdef FC_REQUANT_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_cleared got=%0b exp=0", sat_flag); end
`endif
    drive_beat(32'd1000, 32'd24, 1'b0);
    wait_out(lat);
    checks++; if (act !== exp_act) begin errors++; $display("FAIL sat_act got=%h exp=%h", act, exp_act); end
`ifdef FC_REQUANT_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_set got=%0b exp=1", sat_flag); end
`endif
    @(negedge clk);
  endtask

  task automatic test_cfg_guard;
    int lat;
    do_cfg(M_HALF, 8'd0, 8'd0, 1'b1);
    drive_beat(32'd7, 32'd0, 1'b0);
    do_cfg(M_QTR, 8'd0, 8'd0, 1'b1);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL guard_err_pulse got=%0b exp=1", cfg_err); end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL guard_err_one_cycle got=%0b exp=0", cfg_err); end
    wait_out(lat);
    checks++; if (act !== 8'h04 || lat < 0) begin errors++; $display("FAIL guard_old_mult got=%h exp=04", act); end
    @(negedge clk);
    checks++; if (count !== 16'd1) begin errors++; $display("FAIL guard_count_before got=%0d exp=1", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL guard_idle got=%0b exp=0", busy); end
    do_cfg(M_QTR, 8'd0, 8'd0, 1'b1);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL guard_accept_err got=%0b exp=0", cfg_err); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL guard_count_clear got=%0d exp=0", count); end
    drive_beat(32'd7, 32'd0, 1'b0);
    wait_out(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL guard_latency got=%0d exp=4", lat); end
    checks++; if (act !== 8'h02) begin errors++; $display("FAIL guard_new_mult got=%h exp=02", act); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int sent, got;
    logic in_x, out_x, saw_stall;
    do_cfg(M_HALF, 8'd0, 8'd0, 1'b1);
    sent = 0; got = 0; saw_stall = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      ds_ready = !(cyc >= 3 && cyc <= 9);
      in_valid = (sent < 10);
      acc      = 32'(2 * sent + 1);
      bias     = 32'd0;
      in_last  = (sent == 9);
      #1;
      in_x  = in_valid && out_ready;
      out_x = out_valid && ds_ready;
      if (!out_ready) saw_stall = 1'b1;
      if (out_x) begin
        checks++; if (act !== 8'(got + 1)) begin errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", got, act, 8'(got + 1)); end
        checks++; if (out_last !== (got == 9)) begin errors++; $display("FAIL bp_last[%0d] got=%0b exp=%0b", got, out_last, (got == 9)); end
        got++;
      end
      if (in_x) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; ds_ready = 1'b1;
    checks++; if (got !== 10) begin errors++; $display("FAIL bp_beats got=%0d exp=10", got); end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_ready_drop got=%0b exp=1", saw_stall); end
    checks++; if (count !== 16'd10) begin errors++; $display("FAIL bp_count got=%0d exp=10", count); end
  endtask

  task automatic test_midstream_reset;
    logic stale;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; acc = 32'(5 + 2 * i); bias = 32'd0; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_busy_before got=%0b exp=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%0b exp=0", busy); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", count); end
    rst = 1'b0;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mrst_stale got=%0b exp=0", stale); end
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0; cfg_relu = 1'b1;
    in_valid = 1'b0; acc = '0; bias = '0; in_last = 1'b0; ds_ready = 1'b1;
    test_reset();
    test_rounding();
    test_relu();
    test_saturation();
    test_cfg_guard();
    test_backpressure();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
